ram_rw_host: RTL
================

Name: ram_rw_host

Overview:
- Host-side initiator for the UART RAM read/write command protocol; the responder is the on-chip loader that owns CPU reset and the RAM back-door port.
- Accepts one high-level request (CPU reset/run, config write/read, data write/read), serialises command and payload bytes onto a uart_tx byte interface, and collects response bytes from a uart_rx byte interface.
- Used in board-level host bridges and as the bus-functional master in loader simulations.

Parameters:
- XLEN, 32, width of the address and length fields.
- TIMEOUT, 1000000, maximum idle clock cycles allowed between response bytes before abort.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- op_i  in  3  request opcode: 0 CPU_RST, 1 CPU_RUN, 2 CONF_WR, 3 CONF_RD, 4 DATA_WR, 5 DATA_RD; 6 and 7 are illegal.
- addr_i  in  XLEN  RAM address for CONF_WR.
- len_i  in  XLEN  byte count minus one, for CONF_WR and as the payload/response count of DATA_WR/DATA_RD.
- req_vld_i / req_rdy_o  in/out  1  request handshake.
- wr_data_i  in  8  DATA_WR payload byte.
- wr_data_vld_i / wr_data_rdy_o  in/out  1  payload handshake.
- rd_data_o  out  8  response byte (CONF_RD/DATA_RD).
- rd_data_vld_o / rd_data_rdy_i  out/in  1  response handshake.
- uart_tx_data_o  out  8  byte to UART transmitter.
- uart_tx_data_vld_o / uart_tx_data_rdy_i  out/in  1  transmitter handshake.
- uart_rx_data_i  in  8  byte from UART receiver.
- uart_rx_data_vld_i / uart_rx_data_rdy_o  in/out  1  receiver handshake.
- done_o  out  1  one-cycle pulse when a request completes.
- err_o  out  1  one-cycle pulse on illegal opcode or timeout; coincides with done_o.

Behaviour:
- Reset values: all data outputs 0; all vld, done_o and err_o 0; req_rdy_o 1; uart_rx_data_rdy_o 1; state IDLE.
- Transfers occur on a cycle where vld & rdy are both high. A vld, once raised, holds with stable data until accepted.
- Command bytes: CPU_RST 0x2a, CPU_RUN 0x2b, CONF_WR 0x2c, CONF_RD 0x2d, DATA_WR 0x2e, DATA_RD 0x2f.
- IDLE:
  - req_rdy_o=1. On req accept, latch op, addr and len.
  - Illegal op: done_o and err_o pulse on the next cycle; no UART bytes sent.
  - Otherwise go to SEND_CMD.
- SEND_CMD: present the command byte.
  - On accept: CONF_WR -> SEND_CFG; DATA_WR -> SEND_DATA; CONF_RD -> RECV with count 8; DATA_RD -> RECV with count len+1; CPU_RST/CPU_RUN -> DONE.
- SEND_CFG: 8 bytes, addr then len, each MSB first (addr 0x01234567 sends 01 23 45 67). Then DONE.
- SEND_DATA:
  - uart_tx_data_vld_o = wr_data_vld_i and wr_data_rdy_o = uart_tx_data_rdy_i, as a registered skid of depth 1.
  - Exactly len+1 bytes are forwarded, then DONE. wr_data_rdy_o=0 outside SEND_DATA.
- RECV:
  - Each accepted rx byte is buffered in a 1-entry register, presented on rd_data_o, and held until rd_data_rdy_i.
  - uart_rx_data_rdy_o=0 while the buffer is full.
  - A byte counter decrements per byte; when it reaches 0 and the last byte is consumed, go to DONE.
- Timeout counter: cleared on each rx byte. It counts only in RECV while the buffer is empty. On reaching TIMEOUT: err_o+done_o pulse and return to IDLE; an unconsumed buffered byte is dropped.
- DONE: done_o=1 for one cycle, then IDLE. req_rdy_o=0 in every state except IDLE.
- Outside RECV, uart_rx_data_rdy_o=1 and stray rx bytes are discarded silently.
- len arithmetic is XLEN-bit; len_i = 2^XLEN-1 wraps the count to 0 and is unsupported. The bench must not drive it.
- rst_i asserted mid-request: immediate return to reset values, with no partial byte held on the UART outputs.

Test Plan:
- CPU_RST then CPU_RUN requests, uart_tx_data_rdy_i always 1 -> tx bytes 0x2a, 0x2b; one done_o per request; no err_o.
- CONF_WR addr=0x01234567 len=0 -> tx sequence 2c 01 23 45 67 00 00 00 00; single done_o after the 9th byte.
- DATA_WR len=2, payload aa bb cc, uart_tx_data_rdy_i toggling every 3 cycles -> tx 2e aa bb cc; wr_data_rdy_o low after the 3rd byte; done_o once.
- DATA_RD len=1, responder returns 5a a5, rd_data_rdy_i held low 10 cycles -> rd_data_o 5a then a5 in order; uart_rx_data_rdy_o=0 while the buffer is full; done_o after a5 is consumed.
- CONF_RD with TIMEOUT=50 and only 3 response bytes -> 3 bytes delivered; err_o+done_o 50 cycles after the 3rd byte; req_rdy_o=1 the next cycle.
- op_i=6 -> no tx activity; err_o+done_o pulse; then rst_i asserted during a DATA_WR -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ram_rw_host.sv
// ram_rw_host: host-side initiator for the UART RAM read/write loader.
// Serialises one request onto uart_tx and collects its response from uart_rx.
module ram_rw_host #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] len_i,
  input  logic            req_vld_i,
  output logic            req_rdy_o,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_data_vld_i,
  output logic            wr_data_rdy_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_data_vld_o,
  input  logic            rd_data_rdy_i,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  input  logic [7:0]      uart_rx_data_i,
  input  logic            uart_rx_data_vld_i,
  output logic            uart_rx_data_rdy_o,
  output logic            done_o,
  output logic            err_o
);
  localparam int CFG_BYTES = 2 * XLEN / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_CFG,
    SEND_DATA,
    RECV,
    DONE,
    ERR
  } state_t;

  state_t state, state_n;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   len_q;
  logic [XLEN-1:0]   cnt;
  logic [2*XLEN-1:0] sh;
  logic [7:0]        skid_q;
  logic              skid_vld;
  logic [7:0]        buf_q;
  logic              buf_vld;
  logic [TW-1:0]     tmo;
  logic [7:0]        cmd;

  logic req_acc, cmd_acc, cfg_acc;
  logic wr_acc, out_acc;
  logic rx_acc, rx_take, rd_acc;
  logic tmo_hit, cnt_zero;

  assign req_rdy_o = state == IDLE;
  assign req_acc   = req_rdy_o & req_vld_i;
  assign cnt_zero  = cnt == '0;
  assign cmd_acc   = (state == SEND_CMD) & uart_tx_data_rdy_i;
  assign cfg_acc   = (state == SEND_CFG) & uart_tx_data_rdy_i;
  assign out_acc   = (state == SEND_DATA) & skid_vld
                   & uart_tx_data_rdy_i;

  // Payload skid: refill while the held byte is leaving.
  assign wr_data_rdy_o = (state == SEND_DATA) & ~cnt_zero
                       & (~skid_vld | uart_tx_data_rdy_i);
  assign wr_acc = wr_data_vld_i & wr_data_rdy_o;

  assign uart_rx_data_rdy_o = ~((state == RECV) & buf_vld);
  assign rx_acc  = uart_rx_data_vld_i & uart_rx_data_rdy_o;
  assign rx_take = rx_acc & (state == RECV);
  assign rd_data_o     = buf_q;
  assign rd_data_vld_o = buf_vld;
  assign rd_acc  = buf_vld & rd_data_rdy_i;

  assign tmo_hit = (state == RECV) & ~buf_vld & ~rx_acc
                 & (tmo == TW'(TIMEOUT - 1));

  assign done_o = (state == DONE) | (state == ERR);
  assign err_o  = state == ERR;

  always_comb begin
    cmd = 8'h00;
    unique case (op_q)
      3'd0:    cmd = 8'h2a;
      3'd1:    cmd = 8'h2b;
      3'd2:    cmd = 8'h2c;
      3'd3:    cmd = 8'h2d;
      3'd4:    cmd = 8'h2e;
      3'd5:    cmd = 8'h2f;
      default: cmd = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n            = state;
    uart_tx_data_o     = 8'h00;
    uart_tx_data_vld_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_vld_i)
          state_n = (op_i > 3'd5) ? ERR : SEND_CMD;
      end
      SEND_CMD: begin
        uart_tx_data_o     = cmd;
        uart_tx_data_vld_o = 1'b1;
        if (uart_tx_data_rdy_i) begin
          unique case (op_q)
            3'd2:       state_n = SEND_CFG;
            3'd4:       state_n = SEND_DATA;
            3'd3, 3'd5: state_n = RECV;
            default:    state_n = DONE;
          endcase
        end
      end
      SEND_CFG: begin
        uart_tx_data_o     = sh[2*XLEN-1 -: 8];
        uart_tx_data_vld_o = 1'b1;
        if (uart_tx_data_rdy_i && cnt_zero)
          state_n = DONE;
      end
      SEND_DATA: begin
        uart_tx_data_o     = skid_q;
        uart_tx_data_vld_o = skid_vld;
        if (cnt_zero && (!skid_vld || uart_tx_data_rdy_i))
          state_n = DONE;
      end
      RECV: begin
        if (tmo_hit)
          state_n = ERR;
        else if (rd_acc && cnt_zero)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      len_q    <= '0;
      sh       <= '0;
      cnt      <= '0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      buf_q    <= '0;
      buf_vld  <= 1'b0;
      tmo      <= '0;
    end else begin
      if (req_acc) begin
        op_q  <= op_i;
        len_q <= len_i;
        sh    <= {addr_i, len_i};
      end else if (cfg_acc) begin
        sh <= sh << 8;
      end
      // cnt holds bytes left minus one for config, bytes left otherwise
      if (cmd_acc) begin
        unique case (op_q)
          3'd2:    cnt <= XLEN'(CFG_BYTES - 1);
          3'd3:    cnt <= XLEN'(CFG_BYTES);
          default: cnt <= len_q + XLEN'(1);
        endcase
      end else if (cfg_acc || wr_acc || rx_take) begin
        cnt <= cnt - XLEN'(1);
      end
      if (wr_acc) begin
        skid_q   <= wr_data_i;
        skid_vld <= 1'b1;
      end else if (out_acc) begin
        skid_vld <= 1'b0;
      end
      if (rx_take) begin
        buf_q   <= uart_rx_data_i;
        buf_vld <= 1'b1;
      end else if (rd_acc || state_n != RECV) begin
        buf_vld <= 1'b0;
      end
      if (state != RECV || rx_acc)
        tmo <= '0;
      else if (!buf_vld)
        tmo <= tmo + TW'(1);
    end
  end

endmodule
